// File: rtl/dbf_rx_line_seq_if.sv
// Control/status bus of the DBF per-line sequencer.
// master = frame controller, slave = sequencer.
interface dbf_rx_line_seq_if #(
    parameter int ADDR_WD = 10,
    parameter int LINE_WD = 7
);
    logic               frame_start;
    logic               line_trig;
    logic               abort;
    logic               tx_en;
    logic               start;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic [LINE_WD-1:0] line_idx;
    logic               busy;
    logic               line_done;
    logic               frame_done;
    logic               trig_overrun;

    modport master (
        output frame_start, line_trig, abort,
        input  tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx,
        input  busy, line_done, frame_done, trig_overrun
    );

    modport slave (
        input  frame_start, line_trig, abort,
        output tx_en, start, dbf_lut_addr, dbf_lut_we, line_idx,
        output busy, line_done, frame_done, trig_overrun
    );
endinterface

// File: rtl/dbf_rx_line_seq.sv
// Per-scan-line sequencer: TX window, settle gap, RX window with
// one delay-LUT address step per focal zone; tracks line index in frame.
module dbf_rx_line_seq #(
    parameter int ADDR_WD       = 10,
    parameter int LINE_WD       = 7,
    parameter int NUM_LINES     = 128,
    parameter int TX_CYCLES     = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int RX_SAMPLES    = 4096,
    parameter int ZONE_LEN      = 64
) (
    input logic              clk,
    input logic              rst_n,
    dbf_rx_line_seq_if.slave bus
);
    localparam int MAX_AB = (TX_CYCLES > SETTLE_CYCLES) ? TX_CYCLES : SETTLE_CYCLES;
    localparam int MAXC   = (MAX_AB > RX_SAMPLES) ? MAX_AB : RX_SAMPLES;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int ZW     = $clog2(ZONE_LEN);

    localparam logic [CW-1:0]      TX_LAST   = CW'(TX_CYCLES - 1);
    localparam logic [CW-1:0]      SET_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]      RX_LAST   = CW'(RX_SAMPLES - 1);
    localparam logic [ZW-1:0]      ZONE_LAST = ZW'(ZONE_LEN - 1);
    localparam logic [LINE_WD-1:0] LINE_LAST = LINE_WD'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_SETTLE,
        S_RX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ZW-1:0]      zcnt_q, zcnt_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [ADDR_WD-1:0] base_q, base_d;
    logic [LINE_WD-1:0] idx_q, idx_d;
    logic               ovr_q, ovr_d;
    logic               busy;

    assign busy = (state_q != S_IDLE);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            zcnt_q  <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zcnt_q  <= zcnt_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic: abort rolls the LUT address back to the line base.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zcnt_d  = zcnt_q;
        addr_d  = addr_q;
        base_d  = base_q;
        idx_d   = idx_q;
        ovr_d   = busy && bus.line_trig;
        if (busy && bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            zcnt_d  = '0;
            addr_d  = base_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        idx_d  = '0;
                        addr_d = '0;
                    end
                    if (bus.line_trig) begin
                        state_d = S_TX;
                        cnt_d   = '0;
                        base_d  = bus.frame_start ? '0 : addr_q;
                    end
                end
                S_TX: begin
                    if (cnt_q == TX_LAST) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SETTLE: begin
                    zcnt_d = '0;
                    if (cnt_q == SET_LAST) begin
                        state_d = S_RX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RX: begin
                    if (zcnt_q == ZONE_LAST) begin
                        zcnt_d = '0;
                        addr_d = addr_q + ADDR_WD'(1);
                    end else begin
                        zcnt_d = zcnt_q + ZW'(1);
                    end
                    if (cnt_q == RX_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    if (idx_q == LINE_LAST) begin
                        idx_d  = '0;
                        addr_d = '0;
                    end else begin
                        idx_d = idx_q + LINE_WD'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state and counters.
    always_comb begin
        bus.tx_en        = (state_q == S_TX);
        bus.start        = (state_q == S_RX);
        bus.dbf_lut_we   = (state_q == S_RX) && (zcnt_q == '0);
        bus.dbf_lut_addr = addr_q;
        bus.line_idx     = idx_q;
        bus.busy         = busy;
        bus.line_done    = (state_q == S_DONE);
        bus.frame_done   = (state_q == S_DONE) && (idx_q == LINE_LAST);
        bus.trig_overrun = ovr_q;
    end
endmodule
